// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: run-state and debug-port encodings shared by the run controller
// and the board-level status LEDs.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    BRK  = 2'b11
  } runState_t;

  typedef enum logic {
    DBG_IDLE = 1'b0,
    DBG_ACK  = 1'b1
  } dbgState_t;

  function automatic logic isStopped(runState_t s);
    return (s == HALT) || (s == BRK);
  endfunction

endpackage

// File: rtl/run_ctrl_dbg_port.sv
// run_ctrl_dbg_port: read-only debug access to data memory while the core
// is stopped; owns the address mux select and the registered read data.
module run_ctrl_dbg_port
  import run_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       stopped,
  input  logic       resume,
  input  logic       dbgReq,
  input  logic [7:0] dbgAddr,
  input  logic [7:0] cpuMemAddr,
  input  logic [7:0] fromDataMemory,
  output logic [7:0] memAddr,
  output logic       dbgAck,
  output logic [7:0] dbgData
);

  dbgState_t cur;
  dbgState_t nxt;
  logic      serve;

  // a resume request in the same cycle wins; dbgReq stays pending
  assign serve = stopped && !resume && dbgReq && (cur == DBG_IDLE);

  always_comb begin
    nxt = cur;
    unique case (cur)
      DBG_IDLE: if (serve) nxt = DBG_ACK;
      DBG_ACK:  nxt = DBG_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur     <= DBG_IDLE;
      dbgData <= 8'h00;
    end else begin
      cur <= nxt;
      if (serve) dbgData <= fromDataMemory;
    end
  end

  assign memAddr = serve ? dbgAddr : cpuMemAddr;
  assign dbgAck  = (cur == DBG_ACK);

endmodule

// File: rtl/run_controller.sv
// run_controller: run/halt/step sequencer with PC breakpoint and debug read port.
// Optional retired-instruction counter: define RUN_CONTROLLER_RETIRE_COUNT_EN.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter bit RUN_ON_RESET = 1'b0,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             runReq,
  input  logic             haltReq,
  input  logic             stepReq,
  input  logic             bpEnable,
  input  logic [7:0]       bpAddr,
  input  logic [7:0]       pc,
  input  logic [7:0]       cpuMemAddr,
  input  logic             cpuMemWrite,
  input  logic [7:0]       fromDataMemory,
  input  logic             dbgReq,
  input  logic [7:0]       dbgAddr,
  output logic             cpuEn,
  output logic [7:0]       memAddr,
  output logic             memWrite,
  output logic             dbgAck,
  output logic [7:0]       dbgData,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam runState_t RESET_STATE = RUN_ON_RESET ? RUN : HALT;

  runState_t cur;
  runState_t nxt;
  logic      skip;
  logic      skipNxt;
  logic      bpHit;
  logic      en;
  logic      stopped;
  logic      resume;

  always_comb begin
    bpHit   = bpEnable && (pc == bpAddr) && !skip;
    stopped = isStopped(cur);
    resume  = stopped && !haltReq && (stepReq || runReq);
    nxt     = cur;
    skipNxt = skip;
    en      = 1'b0;
    unique case (cur)
      HALT, BRK: begin
        if (!haltReq) begin
          if (stepReq) begin
            nxt     = STEP;
            skipNxt = 1'b1;
          end else if (runReq) begin
            nxt     = RUN;
            skipNxt = 1'b1;
          end
        end
      end
      RUN: begin
        en = !bpHit;
        if (haltReq)    nxt = HALT;
        else if (bpHit) nxt = BRK;
      end
      STEP: begin
        en = 1'b1;
        if (!haltReq && runReq) nxt = RUN;
        else                    nxt = HALT;
      end
    endcase
    // skip only protects the first executed instruction after resuming
    if (en) skipNxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur  <= RESET_STATE;
      skip <= 1'b0;
    end else begin
      cur  <= nxt;
      skip <= skipNxt;
    end
  end

  // held low while in reset even when leaving reset in RUN
  assign cpuEn    = en & rst;
  assign memWrite = cpuMemWrite & cpuEn;
  assign state    = cur;

`ifdef RUN_CONTROLLER_RETIRE_COUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       cnt <= '0;
    else if (cpuEn) cnt <= cnt + CNT_W'(1);
  end

  assign retired = cnt;
`else
  assign retired = '0;
`endif

  run_ctrl_dbg_port uDbg (
    .clk            (clk),
    .rst            (rst),
    .stopped        (stopped),
    .resume         (resume),
    .dbgReq         (dbgReq),
    .dbgAddr        (dbgAddr),
    .cpuMemAddr     (cpuMemAddr),
    .fromDataMemory (fromDataMemory),
    .memAddr        (memAddr),
    .dbgAck         (dbgAck),
    .dbgData        (dbgData)
  );

endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: directed scenarios for run_controller with a tiny
// core PC model and a static data-memory table.
module tb_run_controller;

  logic        clk;
  logic        rst;
  logic        runReq;
  logic        haltReq;
  logic        stepReq;
  logic        bpEnable;
  logic [7:0]  bpAddr;
  logic [7:0]  pc;
  logic [7:0]  cpuMemAddr;
  logic        cpuMemWrite;
  logic [7:0]  fromDataMemory;
  logic        dbgReq;
  logic [7:0]  dbgAddr;
  logic        cpuEn;
  logic [7:0]  memAddr;
  logic        memWrite;
  logic        dbgAck;
  logic [7:0]  dbgData;
  logic [1:0]  state;
  logic [15:0] retired;

  logic [7:0]  mem [256];
  int          nCmp;
  int          nErr;

  run_controller #(.RUN_ON_RESET(1'b0), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .runReq         (runReq),
    .haltReq        (haltReq),
    .stepReq        (stepReq),
    .bpEnable       (bpEnable),
    .bpAddr         (bpAddr),
    .pc             (pc),
    .cpuMemAddr     (cpuMemAddr),
    .cpuMemWrite    (cpuMemWrite),
    .fromDataMemory (fromDataMemory),
    .dbgReq         (dbgReq),
    .dbgAddr        (dbgAddr),
    .cpuEn          (cpuEn),
    .memAddr        (memAddr),
    .memWrite       (memWrite),
    .dbgAck         (dbgAck),
    .dbgData        (dbgData),
    .state          (state),
    .retired        (retired)
  );

  assign fromDataMemory = mem[memAddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] expRet(int n);
`ifdef RUN_CONTROLLER_RETIRE_COUNT_EN
    return 16'(n);
`else
    return (n == -1) ? 16'hFFFF : 16'h0000;
`endif
  endfunction

  // program loops 3..7 so the breakpoint at 5 is revisited
  function automatic logic [7:0] nextPc(logic [7:0] p);
    return (p == 8'd7) ? 8'd3 : p + 8'd1;
  endfunction

  task automatic edgeStep();
    logic e;
    e = cpuEn;
    @(posedge clk);
    #1;
    if (e) pc = nextPc(pc);
  endtask

  // called at a negedge; returns at the negedge where BRK is seen
  task automatic runUntilBrk(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (state == 2'b11) break;
      if (cpuEn) n++;
      edgeStep();
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2;
    nCmp++; if (state !== 2'b00) begin nErr++; $display("FAIL reset_state got %b want 00", state); end
    nCmp++; if (cpuEn !== 1'b0) begin nErr++; $display("FAIL reset_cpuEn got %b want 0", cpuEn); end
    nCmp++; if (memWrite !== 1'b0) begin nErr++; $display("FAIL reset_memWrite got %b want 0", memWrite); end
    nCmp++; if (dbgAck !== 1'b0) begin nErr++; $display("FAIL reset_dbgAck got %b want 0", dbgAck); end
    nCmp++; if (dbgData !== 8'h00) begin nErr++; $display("FAIL reset_dbgData got %h want 00", dbgData); end
    nCmp++; if (retired !== 16'h0) begin nErr++; $display("FAIL reset_retired got %0d want 0", retired); end
    @(negedge clk);
    rst = 1'b1;
    edgeStep();
    @(negedge clk);
    nCmp++; if (state !== 2'b00 || cpuEn !== 1'b0) begin nErr++; $display("FAIL post_reset got state=%b en=%b want 00/0", state, cpuEn); end
    edgeStep();
  endtask

  task automatic test_step();
    pc = 8'h00;
    stepReq = 1'b1;
    @(negedge clk);
    nCmp++; if (cpuEn !== 1'b0) begin nErr++; $display("FAIL step_req_cycle_en got %b want 0", cpuEn); end
    edgeStep();
    stepReq = 1'b0;
    @(negedge clk);
    nCmp++; if (cpuEn !== 1'b1 || state !== 2'b10) begin nErr++; $display("FAIL step_exec got en=%b state=%b want 1/10", cpuEn, state); end
    edgeStep();
    @(negedge clk);
    nCmp++; if (cpuEn !== 1'b0 || state !== 2'b00) begin nErr++; $display("FAIL step_done got en=%b state=%b want 0/00", cpuEn, state); end
    nCmp++; if (pc !== 8'h01) begin nErr++; $display("FAIL step_pc got %h want 01", pc); end
    nCmp++; if (retired !== expRet(1)) begin nErr++; $display("FAIL step_retired got %0d want %0d", retired, expRet(1)); end
    edgeStep();
  endtask

  task automatic test_breakpoint();
    int n;
    pc = 8'h00;
    bpEnable = 1'b1;
    bpAddr = 8'h05;
    runReq = 1'b1;
    @(negedge clk);
    edgeStep();
    runReq = 1'b0;
    @(negedge clk);
    runUntilBrk(n);
    nCmp++; if (n != 5) begin nErr++; $display("FAIL bp_count got %0d want 5", n); end
    nCmp++; if (state !== 2'b11 || cpuEn !== 1'b0) begin nErr++; $display("FAIL bp_state got state=%b en=%b want 11/0", state, cpuEn); end
    nCmp++; if (pc !== 8'h05) begin nErr++; $display("FAIL bp_pc got %h want 05", pc); end
    nCmp++; if (retired !== expRet(6)) begin nErr++; $display("FAIL bp_retired got %0d want %0d", retired, expRet(6)); end
    edgeStep();
  endtask

  task automatic test_resume();
    int n;
    runReq = 1'b1;
    @(negedge clk);
    nCmp++; if (cpuEn !== 1'b0) begin nErr++; $display("FAIL resume_req_en got %b want 0", cpuEn); end
    edgeStep();
    runReq = 1'b0;
    @(negedge clk);
    nCmp++; if (cpuEn !== 1'b1 || pc !== 8'h05) begin nErr++; $display("FAIL resume_skip got en=%b pc=%h want 1/05", cpuEn, pc); end
    runUntilBrk(n);
    nCmp++; if (n != 5) begin nErr++; $display("FAIL rehit_count got %0d want 5", n); end
    nCmp++; if (state !== 2'b11 || pc !== 8'h05) begin nErr++; $display("FAIL rehit_state got state=%b pc=%h want 11/05", state, pc); end
    nCmp++; if (retired !== expRet(11)) begin nErr++; $display("FAIL rehit_retired got %0d want %0d", retired, expRet(11)); end
    edgeStep();
  endtask

  task automatic test_halt_pending_dbg();
    bpEnable = 1'b0;
    cpuMemWrite = 1'b1;
    cpuMemAddr = 8'h40;
    dbgAddr = 8'h22;
    dbgReq = 1'b1;
    runReq = 1'b1;
    @(negedge clk);
    nCmp++; if (memAddr !== 8'h40 || dbgAck !== 1'b0) begin nErr++; $display("FAIL run_beats_dbg got addr=%h ack=%b want 40/0", memAddr, dbgAck); end
    edgeStep();
    runReq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nCmp++; if (cpuEn !== 1'b1 || memWrite !== 1'b1) begin nErr++; $display("FAIL run_write c%0d got en=%b we=%b want 1/1", i, cpuEn, memWrite); end
      nCmp++; if (dbgAck !== 1'b0 || memAddr !== 8'h40) begin nErr++; $display("FAIL dbg_pending c%0d got ack=%b addr=%h want 0/40", i, dbgAck, memAddr); end
      edgeStep();
    end
    haltReq = 1'b1;
    @(negedge clk);
    nCmp++; if (cpuEn !== 1'b1) begin nErr++; $display("FAIL halt_cycle_en got %b want 1", cpuEn); end
    edgeStep();
    haltReq = 1'b0;
    @(negedge clk);
    nCmp++; if (state !== 2'b00 || cpuEn !== 1'b0 || memWrite !== 1'b0) begin nErr++; $display("FAIL halted got state=%b en=%b we=%b want 00/0/0", state, cpuEn, memWrite); end
    nCmp++; if (memAddr !== 8'h22 || dbgAck !== 1'b0) begin nErr++; $display("FAIL pending_served got addr=%h ack=%b want 22/0", memAddr, dbgAck); end
    edgeStep();
    @(negedge clk);
    nCmp++; if (dbgAck !== 1'b1 || dbgData !== 8'h5A) begin nErr++; $display("FAIL pending_ack got ack=%b data=%h want 1/5a", dbgAck, dbgData); end
    edgeStep();
    dbgReq = 1'b0;
    nCmp++; if (retired !== expRet(15)) begin nErr++; $display("FAIL halt_retired got %0d want %0d", retired, expRet(15)); end
  endtask

  task automatic test_debug_read();
    dbgAddr = 8'h20;
    dbgReq = 1'b1;
    @(negedge clk);
    nCmp++; if (memAddr !== 8'h20 || dbgAck !== 1'b0 || memWrite !== 1'b0) begin nErr++; $display("FAIL dbg_n got addr=%h ack=%b we=%b want 20/0/0", memAddr, dbgAck, memWrite); end
    edgeStep();
    @(negedge clk);
    nCmp++; if (dbgAck !== 1'b1 || dbgData !== 8'hA5) begin nErr++; $display("FAIL dbg_n1 got ack=%b data=%h want 1/a5", dbgAck, dbgData); end
    nCmp++; if (memAddr !== 8'h40 || memWrite !== 1'b0) begin nErr++; $display("FAIL dbg_n1_bus got addr=%h we=%b want 40/0", memAddr, memWrite); end
    edgeStep();
    dbgReq = 1'b0;
    @(negedge clk);
    nCmp++; if (dbgAck !== 1'b0 || dbgData !== 8'hA5) begin nErr++; $display("FAIL dbg_idle got ack=%b data=%h want 0/a5", dbgAck, dbgData); end
    edgeStep();
  endtask

  task automatic test_priority();
    stepReq = 1'b1;
    haltReq = 1'b1;
    @(negedge clk);
    nCmp++; if (cpuEn !== 1'b0) begin nErr++; $display("FAIL halt_wins_en got %b want 0", cpuEn); end
    edgeStep();
    stepReq = 1'b0;
    haltReq = 1'b0;
    @(negedge clk);
    nCmp++; if (state !== 2'b00 || cpuEn !== 1'b0) begin nErr++; $display("FAIL halt_wins got state=%b en=%b want 00/0", state, cpuEn); end
    edgeStep();
    stepReq = 1'b1;
    dbgReq = 1'b1;
    dbgAddr = 8'h21;
    @(negedge clk);
    nCmp++; if (memAddr !== 8'h40 || dbgAck !== 1'b0) begin nErr++; $display("FAIL step_beats_dbg got addr=%h ack=%b want 40/0", memAddr, dbgAck); end
    edgeStep();
    stepReq = 1'b0;
    @(negedge clk);
    nCmp++; if (cpuEn !== 1'b1 || state !== 2'b10 || dbgAck !== 1'b0) begin nErr++; $display("FAIL step_first got en=%b state=%b ack=%b want 1/10/0", cpuEn, state, dbgAck); end
    edgeStep();
    @(negedge clk);
    nCmp++; if (memAddr !== 8'h21 || dbgAck !== 1'b0 || cpuEn !== 1'b0) begin nErr++; $display("FAIL dbg_after_step got addr=%h ack=%b en=%b want 21/0/0", memAddr, dbgAck, cpuEn); end
    edgeStep();
    @(negedge clk);
    nCmp++; if (dbgAck !== 1'b1 || dbgData !== 8'h3C) begin nErr++; $display("FAIL ack_after_step got ack=%b data=%h want 1/3c", dbgAck, dbgData); end
    edgeStep();
    dbgReq = 1'b0;
    nCmp++; if (retired !== expRet(16)) begin nErr++; $display("FAIL prio_retired got %0d want %0d", retired, expRet(16)); end
  endtask

  task automatic test_reset_midrun();
    cpuMemWrite = 1'b1;
    runReq = 1'b1;
    @(negedge clk);
    edgeStep();
    runReq = 1'b0;
    @(negedge clk);
    nCmp++; if (cpuEn !== 1'b1 || memWrite !== 1'b1) begin nErr++; $display("FAIL midrun_active got en=%b we=%b want 1/1", cpuEn, memWrite); end
    edgeStep();
    rst = 1'b0;
    #1;
    nCmp++; if (cpuEn !== 1'b0 || memWrite !== 1'b0 || dbgAck !== 1'b0) begin nErr++; $display("FAIL midrun_rst_out got en=%b we=%b ack=%b want 0/0/0", cpuEn, memWrite, dbgAck); end
    nCmp++; if (state !== 2'b00 || retired !== 16'h0 || dbgData !== 8'h00) begin nErr++; $display("FAIL midrun_rst_regs got state=%b ret=%0d data=%h want 00/0/00", state, retired, dbgData); end
    @(negedge clk);
    rst = 1'b1;
    edgeStep();
    @(negedge clk);
    nCmp++; if (state !== 2'b00 || cpuEn !== 1'b0) begin nErr++; $display("FAIL after_rst got state=%b en=%b want 00/0", state, cpuEn); end
  endtask

  initial begin
    nCmp = 0;
    nErr = 0;
    rst = 1'b0;
    runReq = 1'b0;
    haltReq = 1'b0;
    stepReq = 1'b0;
    bpEnable = 1'b0;
    bpAddr = 8'h00;
    pc = 8'h00;
    cpuMemAddr = 8'h40;
    cpuMemWrite = 1'b1;
    dbgReq = 1'b0;
    dbgAddr = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'hA5;
    mem[8'h21] = 8'h3C;
    mem[8'h22] = 8'h5A;
    mem[8'h40] = 8'hEE;
    test_reset();
    cpuMemWrite = 1'b0;
    test_step();
    test_breakpoint();
    test_resume();
    test_halt_pending_dbg();
    test_debug_read();
    test_priority();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
